// File: rtl/cix32_event_dispatch.sv
// Exception/interrupt dispatcher: queues exception vectors, edge-detects IRQ lines,
// and issues one acknowledged request at a time to the control register file.
module cix32_event_dispatch #(
  parameter logic [7:0] IRQ_VECTOR_BASE = 8'h20,
  parameter int         EXC_FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              exc_valid,
  input  logic [7:0]                        exc_vector,
  input  logic [7:0]                        irq_lines,
  input  logic                              interrupt_enabled,
  input  logic                              eoi,
  input  logic                              overflow_clr,
  output logic                              exception_req,
  output logic [7:0]                        exception_vector,
  input  logic                              exception_ack,
  output logic                              interrupt_req,
  output logic [7:0]                        interrupt_vector,
  input  logic                              interrupt_ack,
  output logic [7:0]                        irq_pending,
  output logic [7:0]                        irq_in_service,
  output logic [$clog2(EXC_FIFO_DEPTH):0]   exc_count,
  output logic                              exc_overflow,
  output logic [1:0]                        o_dbg_state
);

  // Handshake: a request (exception_req / interrupt_req) stays high with a stable
  // vector until its ack is sampled high at a rising edge; the request drops on that
  // same edge. Acks seen while the matching request is low are ignored.

  localparam int AW = $clog2(EXC_FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXC_REQ = 2'd1,
    S_IRQ_REQ = 2'd2
  } state_t;

  state_t        r_state;
  logic [7:0]    r_fifo [EXC_FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [7:0]    r_irq_prev;
  logic [7:0]    r_irq_pending;
  logic [7:0]    r_irq_in_service;
  logic [2:0]    r_irq_idx;
  logic          r_exc_req;
  logic [7:0]    r_exc_vec;
  logic          r_irq_req;
  logic [7:0]    r_irq_vec;

  logic          w_full;
  logic          w_empty;
  logic          w_exc_pop;
  logic          w_irq_take;
  logic          w_push;
  logic          w_drop;
  logic [7:0]    w_irq_rise;
  logic [7:0]    w_irq_done;
  logic [2:0]    w_irq_sel;

  assign w_full     = (r_count == CW'(EXC_FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_exc_pop  = (r_state == S_EXC_REQ) && r_exc_req && exception_ack;
  assign w_irq_take = (r_state == S_IRQ_REQ) && r_irq_req && interrupt_ack;
  // A pop in the same cycle frees a slot, so a full queue still accepts the push.
  assign w_push     = exc_valid && (!w_full || w_exc_pop);
  assign w_drop     = exc_valid && w_full && !w_exc_pop;
  assign w_irq_rise = irq_lines & ~r_irq_prev;
  assign w_irq_done = w_irq_take ? (8'd1 << r_irq_idx) : 8'd0;

  always_comb begin
    w_irq_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_irq_pending[i]) w_irq_sel = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= exc_vector;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)    r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_exc_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_exc_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)            r_overflow <= 1'b0;
    else if (w_drop)       r_overflow <= 1'b1;
    else if (overflow_clr) r_overflow <= 1'b0;
  end

  // A fresh edge on the line being acknowledged keeps it pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_irq_prev       <= 8'h00;
      r_irq_pending    <= 8'h00;
      r_irq_in_service <= 8'h00;
    end else begin
      r_irq_prev       <= irq_lines;
      r_irq_pending    <= (r_irq_pending & ~w_irq_done) | w_irq_rise;
      r_irq_in_service <= (r_irq_in_service & ~{8{eoi}}) | w_irq_done;
    end
  end

  // The request flag rises one cycle after entering a request state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_exc_req <= 1'b0;
      r_exc_vec <= 8'h00;
      r_irq_req <= 1'b0;
      r_irq_vec <= 8'h00;
      r_irq_idx <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state   <= S_EXC_REQ;
            r_exc_vec <= r_fifo[r_rd_ptr];
          end else if (interrupt_enabled && (r_irq_in_service == 8'h00) &&
                       (r_irq_pending != 8'h00)) begin
            r_state   <= S_IRQ_REQ;
            r_irq_idx <= w_irq_sel;
            r_irq_vec <= IRQ_VECTOR_BASE + {5'd0, w_irq_sel};
          end
        end
        S_EXC_REQ: begin
          if (!r_exc_req) begin
            r_exc_req <= 1'b1;
          end else if (exception_ack) begin
            r_exc_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_IRQ_REQ: begin
          if (!r_irq_req) begin
            r_irq_req <= 1'b1;
          end else if (interrupt_ack) begin
            r_irq_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign exception_req    = r_exc_req;
  assign exception_vector = r_exc_vec;
  assign interrupt_req    = r_irq_req;
  assign interrupt_vector = r_irq_vec;
  assign irq_pending      = r_irq_pending;
  assign irq_in_service   = r_irq_in_service;
  assign exc_count        = r_count;
  assign exc_overflow     = r_overflow;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_cix32_event_dispatch.sv
// Directed bench for cix32_event_dispatch: driver pushes expected {kind,vector}
// events, a negedge monitor pops them whenever a request rises.
module tb_cix32_event_dispatch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       exc_valid;
  logic [7:0] exc_vector;
  logic [7:0] irq_lines;
  logic       interrupt_enabled;
  logic       eoi;
  logic       overflow_clr;
  logic       exception_req;
  logic [7:0] exception_vector;
  logic       exception_ack;
  logic       interrupt_req;
  logic [7:0] interrupt_vector;
  logic       interrupt_ack;
  logic [7:0] irq_pending;
  logic [7:0] irq_in_service;
  logic [2:0] exc_count;
  logic       exc_overflow;
  logic [1:0] o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];

  localparam logic K_EXC = 1'b0;
  localparam logic K_IRQ = 1'b1;

  cix32_event_dispatch #(
    .IRQ_VECTOR_BASE(8'h20),
    .EXC_FIFO_DEPTH (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .exc_valid        (exc_valid),
    .exc_vector       (exc_vector),
    .irq_lines        (irq_lines),
    .interrupt_enabled(interrupt_enabled),
    .eoi              (eoi),
    .overflow_clr     (overflow_clr),
    .exception_req    (exception_req),
    .exception_vector (exception_vector),
    .exception_ack    (exception_ack),
    .interrupt_req    (interrupt_req),
    .interrupt_vector (interrupt_vector),
    .interrupt_ack    (interrupt_ack),
    .irq_pending      (irq_pending),
    .irq_in_service   (irq_in_service),
    .exc_count        (exc_count),
    .exc_overflow     (exc_overflow),
    .o_dbg_state      (o_dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_event(input logic kind, input logic [7:0] vec);
    exp_q.push_back({kind, vec});
  endtask

  task automatic strobe_exc(input logic [7:0] vec, input bit accepted);
    exc_valid  = 1'b1;
    exc_vector = vec;
    if (accepted) expect_event(K_EXC, vec);
    tick();
    exc_valid = 1'b0;
  endtask

  task automatic wait_exc(input int max_cycles);
    int n = 0;
    while (!exception_req && n < max_cycles) begin
      tick();
      n++;
    end
    check("exc_req_wait", exception_req, 1);
  endtask

  task automatic wait_irq(input int max_cycles);
    int n = 0;
    while (!interrupt_req && n < max_cycles) begin
      tick();
      n++;
    end
    check("irq_req_wait", interrupt_req, 1);
  endtask

  task automatic ack_exc();
    exception_ack = 1'b1;
    tick();
    exception_ack = 1'b0;
    check("exc_req_drop", exception_req, 0);
  endtask

  task automatic ack_irq();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    check("irq_req_drop", interrupt_req, 0);
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  // Scoreboard monitor
  logic       m_prev_exc = 1'b0;
  logic       m_prev_irq = 1'b0;
  logic [7:0] m_exc_vec  = 8'h00;
  logic [7:0] m_irq_vec  = 8'h00;

  task automatic pop_cmp(input string name, input logic [8:0] act);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected event %0h, nothing expected", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    check("req_mutex", exception_req & interrupt_req, 0);
    if (exception_req && !m_prev_exc) begin
      pop_cmp("exc_event", {K_EXC, exception_vector});
      m_exc_vec = exception_vector;
    end else if (exception_req) begin
      check("exc_vec_stable", exception_vector, m_exc_vec);
    end
    if (interrupt_req && !m_prev_irq) begin
      pop_cmp("irq_event", {K_IRQ, interrupt_vector});
      m_irq_vec = interrupt_vector;
    end else if (interrupt_req) begin
      check("irq_vec_stable", interrupt_vector, m_irq_vec);
    end
    m_prev_exc = exception_req;
    m_prev_irq = interrupt_req;
  end

  // Directed stimulus
  initial begin
    rst_n = 1'b0; exc_valid = 1'b0; exc_vector = 8'h00; irq_lines = 8'h00;
    interrupt_enabled = 1'b0; eoi = 1'b0; overflow_clr = 1'b0;
    exception_ack = 1'b0; interrupt_ack = 1'b0;
    repeat (3) tick();

    check("rst_exc_req", exception_req, 0);
    check("rst_irq_req", interrupt_req, 0);
    check("rst_count", exc_count, 0);
    check("rst_overflow", exc_overflow, 0);
    check("rst_pending", irq_pending, 0);
    check("rst_in_service", irq_in_service, 0);
    check("rst_state", o_dbg_state, 0);
    rst_n = 1'b1;
    tick();

    // Single exception, latency and ack
    strobe_exc(8'h0E, 1'b1);
    check("t1_count_push", exc_count, 1);
    check("t1_req_n0", exception_req, 0);
    tick();
    check("t1_req_n1", exception_req, 0);
    tick();
    check("t1_req_n2", exception_req, 1);
    check("t1_vec", exception_vector, 8'h0E);
    ack_exc();
    check("t1_count_pop", exc_count, 0);

    // Overflow: five strobes into a depth-4 queue, drain in order
    for (int i = 1; i <= 5; i++) strobe_exc(8'(i), i <= 4);
    check("t2_count_full", exc_count, 4);
    check("t2_overflow", exc_overflow, 1);
    for (int i = 0; i < 4; i++) begin
      wait_exc(10);
      ack_exc();
      check("t2_count_drain", exc_count, 3 - i);
    end
    check("t2_overflow_sticky", exc_overflow, 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("t2_overflow_clr", exc_overflow, 0);

    // Overflow set beats clear; push+pop on full queue
    for (int i = 1; i <= 4; i++) strobe_exc(8'hA0 + 8'(i), 1'b1);
    check("t3_count_full", exc_count, 4);
    exc_valid = 1'b1; exc_vector = 8'hFF; overflow_clr = 1'b1;
    tick();
    exc_valid = 1'b0; overflow_clr = 1'b0;
    check("t3_set_wins", exc_overflow, 1);
    check("t3_count_drop", exc_count, 4);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("t3_clr", exc_overflow, 0);
    wait_exc(10);
    exc_valid = 1'b1; exc_vector = 8'hA5; exception_ack = 1'b1;
    expect_event(K_EXC, 8'hA5);
    tick();
    exc_valid = 1'b0; exception_ack = 1'b0;
    check("t3_pushpop_count", exc_count, 4);
    check("t3_pushpop_ovf", exc_overflow, 0);
    check("t3_pushpop_req", exception_req, 0);
    for (int i = 0; i < 4; i++) begin
      wait_exc(10);
      ack_exc();
    end
    check("t3_count_empty", exc_count, 0);

    // Two lines rise together; lowest wins, in-service blocks, eoi releases
    interrupt_enabled = 1'b1;
    irq_lines = 8'b0000_1010;
    expect_event(K_IRQ, 8'h21);
    tick();
    check("t4_pending", irq_pending, 8'h0A);
    check("t4_req_n0", interrupt_req, 0);
    tick();
    check("t4_req_n1", interrupt_req, 0);
    tick();
    check("t4_req_n2", interrupt_req, 1);
    check("t4_vec", interrupt_vector, 8'h21);
    ack_irq();
    check("t4_in_service", irq_in_service, 8'h02);
    check("t4_pending_after", irq_pending, 8'h08);
    strobe_exc(8'h30, 1'b1);
    wait_exc(10);
    ack_exc();
    repeat (4) tick();
    check("t4_blocked", interrupt_req, 0);
    irq_lines = 8'h00;
    expect_event(K_IRQ, 8'h23);
    pulse_eoi();
    check("t4_eoi", irq_in_service, 8'h00);
    wait_irq(10);
    check("t4_vec2", interrupt_vector, 8'h23);
    ack_irq();
    check("t4_in_service2", irq_in_service, 8'h08);
    check("t4_pending_clear", irq_pending, 8'h00);
    pulse_eoi();
    check("t4_eoi2", irq_in_service, 8'h00);
    pulse_eoi();
    check("t4_eoi_idle", irq_in_service, 8'h00);

    // New edge coincident with pending clear keeps the line pending
    irq_lines = 8'h01;
    expect_event(K_IRQ, 8'h20);
    tick();
    irq_lines = 8'h00;
    wait_irq(10);
    interrupt_ack = 1'b1; irq_lines = 8'h01;
    tick();
    interrupt_ack = 1'b0; irq_lines = 8'h00;
    check("t5_pending_kept", irq_pending, 8'h01);
    check("t5_in_service", irq_in_service, 8'h01);
    expect_event(K_IRQ, 8'h20);
    pulse_eoi();
    wait_irq(10);
    ack_irq();
    check("t5_pending_clear", irq_pending, 8'h00);
    pulse_eoi();

    // Exception and IRQ edge in the same cycle; stray interrupt_ack ignored
    irq_lines = 8'h04; exc_valid = 1'b1; exc_vector = 8'h0D;
    expect_event(K_EXC, 8'h0D);
    expect_event(K_IRQ, 8'h22);
    tick();
    exc_valid = 1'b0; irq_lines = 8'h00;
    check("t6_pending", irq_pending, 8'h04);
    check("t6_count", exc_count, 1);
    tick();
    tick();
    check("t6_exc_first", exception_req, 1);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    check("t6_stray_ack_pending", irq_pending, 8'h04);
    check("t6_stray_ack_in_service", irq_in_service, 8'h00);
    ack_exc();
    wait_irq(10);
    check("t6_irq_vec", interrupt_vector, 8'h22);
    ack_irq();
    pulse_eoi();

    // Gate, enable, reset mid-request, line held across reset release
    interrupt_enabled = 1'b0;
    irq_lines = 8'h01;
    tick();
    check("t7_pending", irq_pending, 8'h01);
    repeat (5) tick();
    check("t7_gated", interrupt_req, 0);
    interrupt_enabled = 1'b1;
    expect_event(K_IRQ, 8'h20);
    wait_irq(10);
    check("t7_vec", interrupt_vector, 8'h20);
    rst_n = 1'b0;
    tick();
    check("t7_rst_irq_req", interrupt_req, 0);
    check("t7_rst_irq_vec", interrupt_vector, 8'h00);
    check("t7_rst_exc_req", exception_req, 0);
    check("t7_rst_exc_vec", exception_vector, 8'h00);
    check("t7_rst_pending", irq_pending, 8'h00);
    check("t7_rst_state", o_dbg_state, 0);
    tick();
    rst_n = 1'b1;
    expect_event(K_IRQ, 8'h20);
    tick();
    check("t7_held_edge", irq_pending, 8'h01);
    wait_irq(10);
    ack_irq();
    pulse_eoi();
    irq_lines = 8'h00;

    repeat (4) tick();
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cix32_event_dispatch.md
CIX32_EVENT_DISPATCH -- requirements
Module: cix32_event_dispatch

Interface
REQ-001 SHALL have parameter IRQ_VECTOR_BASE, default 8'h20, vector issued for IRQ line 0 (line i -> base+i, 8-bit wrap).
REQ-002 SHALL have parameter EXC_FIFO_DEPTH, default 4, exception queue entries (power of two, >=2).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset; synchronous and active-low.
REQ-005 SHALL have port exc_valid  in  1  one-cycle exception raise strobe.
REQ-006 SHALL have port exc_vector  in  8  exception vector, qualified by exc_valid.
REQ-007 SHALL have port irq_lines  in  8  external interrupt lines, rising-edge triggered.
REQ-008 SHALL have port interrupt_enabled  in  1  gate for issuing new interrupt requests.
REQ-009 SHALL have port eoi  in  1  one-cycle end-of-interrupt strobe.
REQ-010 SHALL have port overflow_clr  in  1  clears exc_overflow.
REQ-011 SHALL have port exception_req / exception_vector  out  1 / 8  request to control register file, held until acknowledged.
REQ-012 SHALL have port exception_ack  in  1  acknowledge from control register file.
REQ-013 SHALL have port interrupt_req / interrupt_vector  out  1 / 8  interrupt request, held until acknowledged.
REQ-014 SHALL have port interrupt_ack  in  1  acknowledge from control register file.
REQ-015 SHALL have ports irq_pending, irq_in_service  out  8 each  status bitmaps.
REQ-016 SHALL have ports exc_count  out  $clog2(EXC_FIFO_DEPTH)+1  queue occupancy; exc_overflow  out  1  sticky drop flag.

Function
REQ-017 Exception FIFO: exc_valid pushes exc_vector when not full; when full and no pop that cycle, vector dropped and exc_overflow set.
REQ-018 Push and pop in same cycle on full FIFO: push accepted, count unchanged, no overflow.
REQ-019 exc_overflow cleared by overflow_clr; simultaneous set and clear: set wins.
REQ-020 IRQ edge detect: register previous irq_lines; bit i pending set when irq_lines[i]=1 and prev[i]=0; pending stays set on further edges (no count).
REQ-021 FSM states IDLE, EXC_REQ, IRQ_REQ; all request outputs registered from state.
REQ-022 IDLE: FIFO non-empty -> EXC_REQ, exception_vector=FIFO head; exceptions always beat interrupts.
REQ-023 IDLE, FIFO empty, interrupt_enabled=1, irq_in_service=0, irq_pending!=0 -> IRQ_REQ with lowest-index pending line i; interrupt_vector=IRQ_VECTOR_BASE+i.
REQ-024 EXC_REQ: exception_req=1 and vector stable until exception_ack sampled 1; then pop FIFO, return IDLE, exception_req=0 for at least one cycle.
REQ-025 IRQ_REQ: interrupt_req=1 and vector stable until interrupt_ack sampled 1, regardless of interrupt_enabled changes or new exceptions; then clear pending[i], set irq_in_service[i], return IDLE.
REQ-026 New edge on line i in same cycle as its pending clear on ack: pending[i] remains 1.
REQ-027 eoi clears irq_in_service; eoi with in_service=0 ignored; exceptions dispatch while an IRQ is in service.
REQ-028 Acks received outside the matching request state ignored; exception_req and interrupt_req never both 1.
REQ-029 Latency: exc_valid sampled at edge N with FSM idle and FIFO empty -> exception_req=1 after edge N+2; irq edge sampled at N -> irq_pending after N, interrupt_req=1 after N+2.

Reset
REQ-030 rst_n=0 at a rising edge: FSM IDLE, FIFO flushed, exc_count=0, exc_overflow=0, pending=0, in_service=0, irq prev=0, all req/vector outputs 0.
REQ-031 Reset mid-request drops request at that edge with no ack required; line held high across reset release registers as an edge on the first post-reset cycle.

Verification
REQ-032 exc_valid with vector 8'h0E, ack 3 cycles later -> exception_req high 2 cycles after strobe, vector 8'h0E held, low the cycle after ack, exc_count 1->0.
REQ-033 Five exc_valid strobes (8'h01..8'h05) with no ack -> exc_count=4, exc_overflow=1; acking drains 01,02,03,04 in order; overflow_clr clears flag.
REQ-034 irq_lines 8'b0000_1010 rise together, interrupt_enabled=1 -> interrupt_vector=8'h21; after ack, in_service=8'h02, no further req until eoi, then vector 8'h23.
REQ-035 IRQ pending while exc_valid arrives in same cycle -> exception serviced first, interrupt_req follows after exception_ack.
REQ-036 interrupt_enabled=0 with pending=8'h01 -> no interrupt_req; enable -> req with 8'h20; rst_n=0 while req held -> all outputs 0 next cycle.
